// File: rtl/multiplier_pkg.sv
// Shared types and defaults for the pipelined low-half multiplier.
// The partial-product bundle is sized for the widest supported operand.
package multiplier_pkg;

    localparam int MUL_DATA_LEN_DEFAULT       = 32;
    localparam int MUL_PIPELINE_STAGE_DEFAULT = 2;

    localparam int MUL_MAX_LEN  = 64;
    localparam int MUL_MAX_HALF = MUL_MAX_LEN / 2;

    // Narrower instances zero-extend into these fields.
    typedef struct packed {
        logic [MUL_MAX_LEN-1:0]  ll;
        logic [MUL_MAX_HALF-1:0] lh;
        logic [MUL_MAX_HALF-1:0] hl;
    } mul_pp_t;

endpackage

// File: rtl/mul_pipe_reg.sv
// WIDTH x DEPTH register delay line with asynchronous active-low clear.
// DEPTH = 0 degenerates to a wire.
module mul_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused_ctl;
        assign w_unused_ctl = clk ^ rst_n;
        assign o_q = i_d;
    end else begin : g_regs
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/multiplier.sv
// Pipelined unsigned multiplier returning the low DATA_LEN bits of a*b.
// aH*bH never reaches the low half, so only three partial products are formed.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int DATA_LEN       = MUL_DATA_LEN_DEFAULT,
    parameter int PIPELINE_STAGE = MUL_PIPELINE_STAGE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
);

    localparam int H    = DATA_LEN / 2;
    localparam int TAIL = (PIPELINE_STAGE > 2) ? PIPELINE_STAGE - 2 : 0;

    if (DATA_LEN < 2 || (DATA_LEN % 2) != 0 || DATA_LEN > MUL_MAX_LEN) begin : g_bad_len
        $error("multiplier: DATA_LEN must be even, >= 2 and <= %0d", MUL_MAX_LEN);
    end
    if (PIPELINE_STAGE < 1) begin : g_bad_stage
        $error("multiplier: PIPELINE_STAGE must be >= 1");
    end

    logic [H-1:0]        w_al;
    logic [H-1:0]        w_ah;
    logic [H-1:0]        w_bl;
    logic [H-1:0]        w_bh;
    logic [DATA_LEN-1:0] w_ll;
    logic [H-1:0]        w_lh;
    logic [H-1:0]        w_hl;
    mul_pp_t             w_pp;
    mul_pp_t             w_pp_q;
    logic [H-1:0]        w_cross;
    logic [DATA_LEN-1:0] w_sum;
    logic                w_unused_pp;

    assign w_al = a[H-1:0];
    assign w_ah = a[DATA_LEN-1:H];
    assign w_bl = b[H-1:0];
    assign w_bh = b[DATA_LEN-1:H];

    // Cross terms are kept only modulo 2^H; their carries fall off the top.
    assign w_ll = DATA_LEN'(w_al) * DATA_LEN'(w_bl);
    assign w_lh = w_al * w_bh;
    assign w_hl = w_ah * w_bl;

    always_comb begin
        w_pp    = '0;
        w_pp.ll = MUL_MAX_LEN'(w_ll);
        w_pp.lh = MUL_MAX_HALF'(w_lh);
        w_pp.hl = MUL_MAX_HALF'(w_hl);
    end

    if (PIPELINE_STAGE == 1) begin : g_comb
        assign w_pp_q = w_pp;
    end else begin : g_reg
        mul_pp_t r_pp;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pp <= '0;
            end else begin
                r_pp <= w_pp;
            end
        end

        assign w_pp_q = r_pp;
    end

    assign w_cross = w_pp_q.lh[H-1:0] + w_pp_q.hl[H-1:0];
    assign w_sum   = w_pp_q.ll[DATA_LEN-1:0] + {w_cross, {H{1'b0}}};

    // Upper bundle bits are zero padding for narrow instances.
    assign w_unused_pp = ^w_pp_q;

    mul_pipe_reg #(
        .WIDTH(DATA_LEN),
        .DEPTH(TAIL)
    ) u_tail (
        .clk  (clk),
        .rst_n(reset),
        .i_d  (w_sum),
        .o_q  (result)
    );

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench driving four multiplier configurations in lockstep.
// Expected results are queued with their due cycle; a monitor pops them.
module tb_multiplier;

    typedef struct {
        int          due;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e32;
        logic [15:0] e16;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] r_d2;
    logic [31:0] r_d1;
    logic [31:0] r_d4;
    logic [15:0] r_h2;
    logic [31:0] res [4];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    sb_t   q [4][$];
    string names [4] = '{"p2_w32", "p1_w32", "p4_w32", "p2_w16"};
    int    lat   [4] = '{1, 0, 3, 1};

    vec_t dir [12] = '{
        '{32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 16'h002A},
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 16'h0000},
        '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 16'hFFFE},
        '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 16'h0000},
        '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 16'h000F},
        '{32'h0000_0064, 32'h0000_00C8, 32'h0000_4E20, 16'h4E20},
        '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 16'h0001},
        '{32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 16'h0060},
        '{32'h8000_0000, 32'h0000_0003, 32'h8000_0000, 16'h0000},
        '{32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 16'hBEEF},
        '{32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 16'h0001},
        '{32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_0000, 16'h0000}
    };

    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) u_d2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r_d2)
    );
    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) u_d1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r_d1)
    );
    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) u_d4 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r_d4)
    );
    multiplier #(.DATA_LEN(16), .PIPELINE_STAGE(2)) u_h2 (
        .clk(clk), .reset(reset), .a(a[15:0]), .b(b[15:0]), .result(r_h2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        res[0] = r_d2;
        res[1] = r_d1;
        res[2] = r_d4;
        res[3] = {16'h0000, r_h2};
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] m32(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'h0, x} * {32'h0, y};
        return p[31:0];
    endfunction

    function automatic logic [15:0] m16(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0, x} * {16'h0, y};
        return p[15:0];
    endfunction

    function automatic bit sb_empty();
        return q[0].size() == 0 && q[1].size() == 0 &&
               q[2].size() == 0 && q[3].size() == 0;
    endfunction

    task automatic push(input int k, input int due, input logic [31:0] exp);
        sb_t s;
        s.due = due;
        s.exp = exp;
        q[k].push_back(s);
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] e32, input logic [15:0] e16);
        a = va;
        b = vb;
        for (int k = 0; k < 4; k++) begin
            push(k, cyc + lat[k], (k == 3) ? {16'h0000, e16} : e32);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        for (int k = 0; k < 4; k++) begin
            while (q[k].size() > 0 && q[k][0].due <= cyc) begin
                e = q[k].pop_front();
                check(names[k], res[k], e.exp);
            end
        end
    end

    initial begin
        logic [31:0] va;
        logic [31:0] vb;

        #1 reset = 1'b0;
        #1;
        check({names[0], "_rst"}, res[0], 32'h0);
        check({names[2], "_rst"}, res[2], 32'h0);
        check({names[3], "_rst"}, res[3], 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (dir[i]) begin
            @(posedge clk);
            #1 drive(dir[i].a, dir[i].b, dir[i].e32, dir[i].e16);
        end
        repeat (5) begin
            @(posedge clk);
            #1 a = '0;
            b = '0;
        end

        @(posedge clk);
        #1 a = 32'd9;
        b = 32'd9;
        #2 reset = 1'b0;
        #1;
        check({names[0], "_midrst"}, res[0], 32'h0);
        check({names[2], "_midrst"}, res[2], 32'h0);
        check({names[3], "_midrst"}, res[3], 32'h0);
        @(posedge clk);
        #1;
        check({names[0], "_rsthold"}, res[0], 32'h0);
        check({names[2], "_rsthold"}, res[2], 32'h0);
        check({names[3], "_rsthold"}, res[3], 32'h0);
        reset = 1'b1;
        push(2, cyc + 1, 32'h0);
        push(2, cyc + 2, 32'h0);
        drive(32'd2, 32'd3, 32'd6, 16'd6);

        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            va = $urandom;
            vb = $urandom;
            #1 drive(va, vb, m32(va, vb), m16(va[15:0], vb[15:0]));
        end

        for (int i = 0; i < 10 && !sb_empty(); i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        if (!sb_empty()) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0",
                     q[0].size() + q[1].size() + q[2].size() + q[3].size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
